// File: rtl/neuron_score_accumulator_pkg.sv
// rtl/neuron_score_accumulator_pkg.sv - shared widths, FSM states and score type for the classifier output layer
package neuron_pkg;

  localparam int DATA_W      = 8;
  localparam int WGT_W       = 8;
  localparam int ACC_W       = 26;
  localparam int NUM_CLASSES = 10;

  // Product of a zero-extended unsigned feature and a signed weight.
  localparam int PROD_W = DATA_W + WGT_W + 1;

  // Beat counter covers frame lengths up to 1024 beats.
  localparam int CNT_W = 11;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  // Class score, also consumed by the argmax selector.
  typedef logic signed [ACC_W-1:0] score_t;

  function automatic score_t sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/neuron_score_accumulator_if.sv
// rtl/neuron_score_accumulator_if.sv - feature beat stream: one feature plus ten class weights per beat
interface neuron_score_accumulator_if
  import neuron_pkg::*;
();

  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             in_data;
  logic [NUM_CLASSES*WGT_W-1:0]  in_weights;
  logic                          in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_weights,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_weights,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/neuron_score_accumulator_mac_lane.sv
// rtl/neuron_score_accumulator_mac_lane.sv - one class lane: multiply, accumulate, optional ReLU at capture (NEURON_RELU_EN)
module neuron_mac_lane
  import neuron_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    en,
  input  logic [DATA_W-1:0]       data,
  input  logic signed [WGT_W-1:0] weight,
  input  logic                    capture,
  output score_t                  score
);

  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic                     vld_d, vld_q;
  logic                     clr_d, clr_q;
  score_t                   acc_d, acc_q;
  score_t                   out_d, out_q;

  // Stage 1: register the product; the frame-start clear travels alongside it.
  always_comb begin
    prod_d = prod_q;
    vld_d  = en;
    clr_d  = clear & en;
    if (en) begin
      prod_d = PROD_W'($signed({1'b0, data})) * PROD_W'(weight);
    end
  end

  // Stage 2: accumulate; the first product of a frame overwrites the old total.
  always_comb begin
    acc_d = acc_q;
    if (vld_q) begin
      acc_d = (clr_q ? score_t'(0) : acc_q) + sext_prod(prod_q);
    end
  end

  // Output copy happens once per frame, after the last product has landed.
  always_comb begin
    out_d = out_q;
    if (capture) begin
`ifdef NEURON_RELU_EN
      out_d = acc_q[ACC_W-1] ? score_t'(0) : acc_q;
`else
      out_d = acc_q;
`endif
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
      clr_q  <= 1'b0;
      acc_q  <= '0;
      out_q  <= '0;
    end else begin
      prod_q <= prod_d;
      vld_q  <= vld_d;
      clr_q  <= clr_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
    end
  end

  assign score = out_q;

endmodule

// File: rtl/neuron_score_accumulator.sv
// rtl/neuron_score_accumulator.sv - output layer: ten class scores per frame with valid/ready handoff (NEURON_RELU_EN selects ReLU scores)
module neuron_score_accumulator
  import neuron_pkg::*;
#(
  parameter int NUM_FEATURES = 784
) (
  input  logic                         clk,
  input  logic                         GlobalReset,
  neuron_score_accumulator_if.slave    in_if,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic                         frame_err,
  output score_t                       Out_0,
  output score_t                       Out_1,
  output score_t                       Out_2,
  output score_t                       Out_3,
  output score_t                       Out_4,
  output score_t                       Out_5,
  output score_t                       Out_6,
  output score_t                       Out_7,
  output score_t                       Out_8,
  output score_t                       Out_9
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_FEATURES - 1);

  state_t           state_d, state_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             in_ready_d, in_ready_q;
  logic             out_valid_d, out_valid_q;
  logic             frame_err_d, frame_err_q;
  logic             drain_wait_d, drain_wait_q;

  logic             accept;
  logic             first_beat;
  logic             capture;
  logic [CNT_W-1:0] beat_idx;
  logic             idx_is_last;
  score_t           scores [NUM_CLASSES];

  assign accept      = in_if.in_valid & in_ready_q;
  assign beat_idx    = (state_q == IDLE) ? '0 : count_q;
  assign idx_is_last = (beat_idx == LAST_IDX);

  // Frame sequencing: count beats, drain the pipe, then hold scores until taken.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    drain_wait_d = drain_wait_q;
    first_beat   = 1'b0;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          first_beat = 1'b1;
          count_d    = CNT_W'(1);
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (count_q == LAST_IDX) begin
            in_ready_d   = 1'b0;
            drain_wait_d = 1'b0;
            state_d      = DRAIN;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!drain_wait_q) begin
          drain_wait_d = 1'b1;
        end else begin
          capture     = 1'b1;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          count_d     = '0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky end-of-frame marker check; framing itself is set by the count.
  always_comb begin
    frame_err_d = frame_err_q;
    if (accept && (in_if.in_last != idx_is_last)) begin
      frame_err_d = 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      drain_wait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      drain_wait_q <= drain_wait_d;
    end
  end

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
    neuron_mac_lane u_lane (
      .clk     (clk),
      .rst_n   (GlobalReset),
      .clear   (first_beat),
      .en      (accept),
      .data    (in_if.in_data),
      .weight  (in_if.in_weights[k*WGT_W +: WGT_W]),
      .capture (capture),
      .score   (scores[k])
    );
  end

  assign in_if.in_ready = in_ready_q;
  assign out_valid      = out_valid_q;
  assign frame_err      = frame_err_q;
  assign Out_0          = scores[0];
  assign Out_1          = scores[1];
  assign Out_2          = scores[2];
  assign Out_3          = scores[3];
  assign Out_4          = scores[4];
  assign Out_5          = scores[5];
  assign Out_6          = scores[6];
  assign Out_7          = scores[7];
  assign Out_8          = scores[8];
  assign Out_9          = scores[9];

endmodule

// File: tb/tb_neuron_score_accumulator.sv
// tb/tb_neuron_score_accumulator.sv - directed and random frames against a sum-of-products reference
module tb_neuron_score_accumulator;

  localparam int NF_A = 4;
  localparam int NF_B = 784;

  logic clk = 1'b0;
  logic GlobalReset;
  logic a_out_ready, a_out_valid, a_frame_err;
  logic b_out_ready, b_out_valid, b_frame_err;
  logic signed [25:0] a_out [10];
  logic signed [25:0] b_out [10];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  neuron_score_accumulator_if a_if ();
  neuron_score_accumulator_if b_if ();

  neuron_score_accumulator #(.NUM_FEATURES(NF_A)) dut_a (
    .clk(clk), .GlobalReset(GlobalReset), .in_if(a_if),
    .out_ready(a_out_ready), .out_valid(a_out_valid), .frame_err(a_frame_err),
    .Out_0(a_out[0]), .Out_1(a_out[1]), .Out_2(a_out[2]), .Out_3(a_out[3]), .Out_4(a_out[4]),
    .Out_5(a_out[5]), .Out_6(a_out[6]), .Out_7(a_out[7]), .Out_8(a_out[8]), .Out_9(a_out[9])
  );

  neuron_score_accumulator #(.NUM_FEATURES(NF_B)) dut_b (
    .clk(clk), .GlobalReset(GlobalReset), .in_if(b_if),
    .out_ready(b_out_ready), .out_valid(b_out_valid), .frame_err(b_frame_err),
    .Out_0(b_out[0]), .Out_1(b_out[1]), .Out_2(b_out[2]), .Out_3(b_out[3]), .Out_4(b_out[4]),
    .Out_5(b_out[5]), .Out_6(b_out[6]), .Out_7(b_out[7]), .Out_8(b_out[8]), .Out_9(b_out[9])
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint relu(input longint v);
`ifdef NEURON_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic beat_a(input string tag, input logic [7:0] d, input logic [79:0] wv, input logic last);
    int n = 0;
    @(negedge clk);
    a_if.in_valid   = 1'b1;
    a_if.in_data    = d;
    a_if.in_weights = wv;
    a_if.in_last    = last;
    while (!a_if.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, a_if.in_ready, 1);
    @(posedge clk);
  endtask

  task automatic run_frame_a(input string tag, input logic [7:0] d [4], input logic [79:0] w [4],
                             input int last_at, input bit bubbles, input int hold);
    longint expv [10];
    for (int k = 0; k < 10; k++) begin
      expv[k] = 0;
      for (int b = 0; b < NF_A; b++)
        expv[k] += longint'(d[b]) * longint'($signed(w[b][k*8 +: 8]));
      expv[k] = relu(expv[k]);
    end
    for (int b = 0; b < NF_A; b++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          a_if.in_valid = 1'b0;
        end
      end
      beat_a(tag, d[b], w[b], b == last_at);
    end
    @(negedge clk);
    a_if.in_valid = 1'b0;
    chk({tag, "_lat1"}, a_out_valid, 0);
    @(negedge clk);
    chk({tag, "_lat2"}, a_out_valid, 0);
    @(negedge clk);
    chk({tag, "_lat3"}, a_out_valid, 1);
    chk({tag, "_hold_in_ready"}, a_if.in_ready, 0);
    for (int k = 0; k < 10; k++) chk($sformatf("%s_out%0d", tag, k), a_out[k], expv[k]);
    for (int c = 0; c < hold; c++) begin
      a_if.in_valid = 1'b1;
      a_if.in_last  = 1'b0;
      a_if.in_data  = 8'($urandom);
      @(negedge clk);
      chk($sformatf("%s_bp_ready%0d", tag, c), a_if.in_ready, 0);
      chk($sformatf("%s_bp_valid%0d", tag, c), a_out_valid, 1);
      for (int k = 0; k < 10; k++) chk($sformatf("%s_bp%0d_out%0d", tag, c, k), a_out[k], expv[k]);
    end
    a_if.in_valid = 1'b0;
    a_out_ready   = 1'b1;
    @(negedge clk);
    chk({tag, "_consumed_valid"}, a_out_valid, 0);
    chk({tag, "_consumed_ready"}, a_if.in_ready, 1);
    a_out_ready = 1'b0;
  endtask

  task automatic run_frame_b(input string tag, input logic [7:0] wv8);
    longint expv;
    int n;
    expv = relu(longint'(NF_B) * 255 * longint'($signed(wv8)));
    b_if.in_weights = {10{wv8}};
    b_if.in_data    = 8'd255;
    for (int i = 0; i < NF_B; i++) begin
      @(negedge clk);
      b_if.in_valid = 1'b1;
      b_if.in_last  = (i == NF_B - 1);
      n = 0;
      while (!b_if.in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!b_if.in_ready) chk({tag, "_accept"}, b_if.in_ready, 1);
      @(posedge clk);
    end
    @(negedge clk);
    b_if.in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, b_out_valid, 1);
    for (int k = 0; k < 10; k++) chk($sformatf("%s_out%0d", tag, k), b_out[k], expv);
    chk({tag, "_frame_err"}, b_frame_err, 0);
    b_out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_consumed"}, b_out_valid, 0);
    b_out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  d [4];
    logic [79:0] w [4];
    logic [79:0] wv;

    GlobalReset = 1'b0;
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_weights = '0; a_if.in_last = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_weights = '0; b_if.in_last = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", a_if.in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_frame_err", a_frame_err, 0);
    chk("rst_out0", a_out[0], 0);
    chk("rst_out9", a_out[9], 0);
    GlobalReset = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", a_if.in_ready, 1);

    // Uniform frame: data=1, w_k=k -> 4k
    for (int k = 0; k < 10; k++) wv[k*8 +: 8] = 8'(k);
    for (int b = 0; b < 4; b++) begin d[b] = 8'd1; w[b] = wv; end
    run_frame_a("uniform", d, w, 3, 1'b0, 0);
    chk("uniform_frame_err", a_frame_err, 0);

    // Negative weight on class 3
    wv = '0;
    wv[3*8 +: 8] = 8'h80;
    for (int b = 0; b < 4; b++) begin d[b] = 8'd255; w[b] = wv; end
    run_frame_a("negw", d, w, 3, 1'b0, 0);

    // Framing error on beat 1, scores still produced
    for (int b = 0; b < 4; b++) begin
      d[b] = 8'(b + 3);
      for (int k = 0; k < 10; k++) w[b][k*8 +: 8] = 8'(k - 5);
    end
    run_frame_a("ferr", d, w, 1, 1'b0, 0);
    chk("ferr_set", a_frame_err, 1);

    // Backpressure with a beat offered during hold; frame_err stays sticky
    for (int b = 0; b < 4; b++) begin
      d[b] = 8'($urandom);
      for (int k = 0; k < 10; k++) w[b][k*8 +: 8] = 8'($urandom);
    end
    run_frame_a("bp", d, w, 3, 1'b1, 10);
    chk("ferr_sticky", a_frame_err, 1);

    // Reset mid-frame after two beats
    wv = {10{8'd99}};
    beat_a("abort0", 8'd200, wv, 1'b0);
    beat_a("abort1", 8'd201, wv, 1'b0);
    @(negedge clk);
    GlobalReset   = 1'b0;
    a_if.in_valid = 1'b0;
    #1;
    chk("midrst_in_ready", a_if.in_ready, 0);
    chk("midrst_out_valid", a_out_valid, 0);
    chk("midrst_frame_err", a_frame_err, 0);
    chk("midrst_out5", a_out[5], 0);
    @(negedge clk);
    GlobalReset = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin d[b] = 8'd2; w[b] = {10{8'd1}}; end
    run_frame_a("postrst", d, w, 3, 1'b0, 0);

    // Random frames with bubbles
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 4; b++) begin
        d[b] = 8'($urandom);
        for (int k = 0; k < 10; k++) w[b][k*8 +: 8] = 8'($urandom);
      end
      run_frame_a($sformatf("rand%0d", f), d, w, 3, 1'b1, f);
    end
    chk("rand_frame_err", a_frame_err, 0);

    // Full-scale frames on the 784-beat instance
    run_frame_b("full_neg", 8'h80);
    run_frame_b("full_pos", 8'd127);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
